// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide engine.
// The ALU wrapper imports this package to decode funct into an operation.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } muldiv_state_t;

  localparam int MULDIV_ITER    = 32;
  localparam int MULDIV_LATENCY = 34;

  // 0x80000000 has no positive counterpart and stays 0x80000000, read as unsigned.
  function automatic logic [31:0] muldiv_abs(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU engine: one bit per cycle through a shared
// 33-bit add/subtract datapath, sign fix-up via one 64-bit negator.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             validIn,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             validOut,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  muldiv_state_t    r_state;
  muldiv_op_t       r_op;
  logic [4:0]       r_cnt;
  logic             r_sign_a;
  logic             r_sign_b;
  logic             r_div0;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_hi_acc;
  logic [WIDTH-1:0] r_lo_acc;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_valid_out;

  logic             w_is_div;
  logic             w_in_signed;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_add_a;
  logic [WIDTH:0]   w_add_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_mul_top;
  logic [WIDTH-1:0] w_hi_step;
  logic [WIDTH-1:0] w_lo_step;
  logic [WIDTH:0]   w_neg_lo;
  logic [WIDTH-1:0] w_neg_hi;
  logic [WIDTH-1:0] w_hi_fix;
  logic [WIDTH-1:0] w_lo_fix;

  assign w_is_div    = r_op[1];
  assign w_in_signed = ~op[0];
  assign w_mag_a     = muldiv_abs(SrcA, w_in_signed);
  assign w_mag_b     = muldiv_abs(SrcB, w_in_signed);

  // Multiply adds the multiplicand to the upper half; divide subtracts the
  // divisor from the remainder already shifted left by one.
  assign w_add_a = w_is_div ? {r_hi_acc, r_lo_acc[WIDTH-1]} : {1'b0, r_hi_acc};
  assign w_add_b = {1'b0, r_opnd};
  assign w_sum   = w_add_a + (w_add_b ^ {(WIDTH+1){w_is_div}}) + {{WIDTH{1'b0}}, w_is_div};

  assign w_mul_top = r_lo_acc[0] ? w_sum : {1'b0, r_hi_acc};

  always_comb begin
    w_hi_step = w_mul_top[WIDTH:1];
    w_lo_step = {w_mul_top[0], r_lo_acc[WIDTH-1:1]};
    if (w_is_div) begin
      if (!w_sum[WIDTH]) begin
        w_hi_step = w_sum[WIDTH-1:0];
        w_lo_step = {r_lo_acc[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_step = w_add_a[WIDTH-1:0];
        w_lo_step = {r_lo_acc[WIDTH-2:0], 1'b0};
      end
    end
  end

  // 64-bit negator; for divide the carry between halves is cut so quotient
  // and remainder are negated independently.
  assign w_neg_lo = {1'b0, ~r_lo_acc} + {{WIDTH{1'b0}}, 1'b1};
  assign w_neg_hi = ~r_hi_acc + {{(WIDTH-1){1'b0}}, w_is_div | w_neg_lo[WIDTH]};

  always_comb begin
    w_hi_fix = r_hi_acc;
    w_lo_fix = r_lo_acc;
    if (w_is_div) begin
      if (r_sign_a ^ r_sign_b && !r_div0) w_lo_fix = w_neg_lo[WIDTH-1:0];
      if (r_sign_a)                       w_hi_fix = w_neg_hi;
    end else if (r_sign_a ^ r_sign_b) begin
      w_hi_fix = w_neg_hi;
      w_lo_fix = w_neg_lo[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= MULT;
      r_cnt       <= '0;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_div0      <= 1'b0;
      r_opnd      <= '0;
      r_hi_acc    <= '0;
      r_lo_acc    <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= 1'b0;
      case (r_state)
        IDLE: if (validIn) begin
          r_state  <= RUN;
          r_op     <= muldiv_op_t'(op);
          r_cnt    <= 5'(MULDIV_ITER - 1);
          r_sign_a <= w_in_signed & SrcA[WIDTH-1];
          r_sign_b <= w_in_signed & SrcB[WIDTH-1];
          r_div0   <= (SrcB == '0);
          r_hi_acc <= '0;
          r_opnd   <= op[1] ? w_mag_b : w_mag_a;
          r_lo_acc <= op[1] ? w_mag_a : w_mag_b;
        end
        RUN: begin
          r_hi_acc <= w_hi_step;
          r_lo_acc <= w_lo_step;
          if (r_cnt == 5'd0) r_state <= FIX;
          else               r_cnt   <= r_cnt - 5'd1;
        end
        FIX: begin
          r_hi        <= w_hi_fix;
          r_lo        <= w_lo_fix;
          r_valid_out <= 1'b1;
          r_state     <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = (r_state != IDLE);
  assign validOut = r_valid_out;
  assign Hi       = r_hi;
  assign Lo       = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed operations push expected results,
// a negedge monitor pops and checks them whenever validOut is seen.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          acc_edge;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        validIn = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        busy;
  logic        validOut;
  logic [31:0] Hi;
  logic [31:0] Lo;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   vo_count = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .validIn(validIn), .op(op),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .validOut(validOut),
    .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: one pop per validOut cycle.
  always @(negedge clk) begin
    if (rst_n && validOut) begin
      exp_t e;
      vo_count++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_validOut actual=Hi:0x%08h/Lo:0x%08h required=none", Hi, Lo);
      end else begin
        e = q.pop_front();
        check32({e.name, "_hi"}, Hi, e.hi);
        check32({e.name, "_lo"}, Lo, e.lo);
        check_int({e.name, "_latency"}, cyc - e.acc_edge + 1, MULDIV_LATENCY);
        $display("result %s Hi=0x%08h Lo=0x%08h", e.name, Hi, Lo);
      end
    end
  end

  task automatic start(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input string name);
    exp_t e;
    @(negedge clk);
    op = o; SrcA = a; SrcB = b; validIn = 1'b1;
    e.hi = ehi; e.lo = elo; e.acc_edge = cyc + 1; e.name = name;
    q.push_back(e);
    $display("issue %s op=%0d A=0x%08h B=0x%08h", name, o, a, b);
    @(posedge clk);
    #1;
    validIn = 1'b0;
    SrcA = $urandom; SrcB = $urandom; op = 2'($urandom);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL busy_timeout actual=busy required=idle");
        break;
      end
    end
  endtask

  task automatic run_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string name);
    int n;
    start(o, a, b, ehi, elo, name);
    wait_idle(n);
    check_int({name, "_busy_cycles"}, n, MULDIV_LATENCY);
  endtask

  initial begin
    int n;
    int vo_before;

    #1;
    check32("reset_hi", Hi, 32'h0);
    check32("reset_lo", Lo, 32'h0);
    check32("reset_busy", {31'd0, busy}, 32'h0);
    check32("reset_validOut", {31'd0, validOut}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
    run_op(MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg3x7");
    run_op(MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minxmin");
    run_op(MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "mult_m1xm1");
    run_op(DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2");
    run_op(DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       "divu_100by7");
    run_op(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_minbym1");
    run_op(DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, "divu_5by0");
    run_op(DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, "div_neg8by0");

    // A second request mid-operation must be dropped.
    vo_before = vo_count;
    start(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu_ignore2nd");
    repeat (10) @(negedge clk);
    op = MULTU; SrcA = 32'd3; SrcB = 32'd3; validIn = 1'b1;
    @(negedge clk);
    validIn = 1'b0;
    wait_idle(n);
    repeat (40) @(negedge clk);
    check_int("ignore2nd_validOut_count", vo_count - vo_before, 1);
    check32("ignore2nd_idle", {31'd0, busy}, 32'h0);

    // Reset in the middle of an operation discards it.
    start(MULT, 32'd1000, 32'd3, 32'd0, 32'd3000, "mult_reset");
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check32("midreset_hi", Hi, 32'h0);
    check32("midreset_lo", Lo, 32'h0);
    check32("midreset_busy", {31'd0, busy}, 32'h0);
    check32("midreset_validOut", {31'd0, validOut}, 32'h0);
    void'(q.pop_back());
    vo_before = vo_count;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check_int("midreset_no_validOut", vo_count - vo_before, 0);

    run_op(MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, "multu_after_reset");
    repeat (3) @(negedge clk);
    check_int("scoreboard_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
